// File: rtl/hit_new_map.sv
// Hit buffer plus per-event "SSID already seen" map.
// Flags first occurrence of each SSID per event, then clears the map in slices.
module hit_new_map #(
  parameter int SSIDBITS    = 8,
  parameter int HITINFOBITS = 16,
  parameter int FIFODEPTH   = 4,
  parameter int CLEARWIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hitValid,
  input  logic [SSIDBITS-1:0]    hitSSID,
  input  logic [HITINFOBITS-1:0] hitInfo,
  output logic                   hitReady,
  input  logic                   eventEnd,
  input  logic                   hcmReady,
  output logic                   writeRow,
  output logic [SSIDBITS-1:0]    rowToWrite,
  output logic                   SSIDIsNew,
  output logic [HITINFOBITS-1:0] hitInfoOut,
  output logic [SSIDBITS:0]      nNewSSIDs,
  output logic [SSIDBITS:0]      eventNewCount,
  output logic                   clearDone,
  output logic                   busy
);

  localparam int MAPSIZE = 1 << SSIDBITS;
  localparam int PTRW    = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int CNTW    = $clog2(FIFODEPTH) + 1;
  localparam int NSLICE  = MAPSIZE / CLEARWIDTH;
  localparam int SLW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SSIDBITS:0] MAXCNT = (SSIDBITS+1)'(MAPSIZE);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

  state_t state, nextState;

  logic [SSIDBITS-1:0]    fifoSSID [FIFODEPTH];
  logic [HITINFOBITS-1:0] fifoInfo [FIFODEPTH];
  logic [PTRW-1:0]        wrPtr, rdPtr;
  logic [CNTW-1:0]        count;
  logic [MAPSIZE-1:0]     map;
  logic [MAPSIZE-1:0]     clrMask;
  logic [SLW-1:0]         clearPtr;

  logic push, issue, fifoEmpty, lastSlice;
  logic [SSIDBITS-1:0]    headSSID;
  logic [HITINFOBITS-1:0] headInfo;
  logic                   headNew;

  assign fifoEmpty = (count == '0);
  assign hitReady  = (state == RUN) && (count < CNTW'(FIFODEPTH));
  assign push      = hitValid && hitReady;
  assign issue     = !fifoEmpty && hcmReady &&
                     ((state == RUN) || (state == DRAIN));
  assign headSSID  = fifoSSID[rdPtr];
  assign headInfo  = fifoInfo[rdPtr];
  assign headNew   = ~map[headSSID];
  assign lastSlice = (clearPtr == SLW'(NSLICE - 1));
  assign clearDone = (state == DONE);
  assign busy      = (state != RUN) || !fifoEmpty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= nextState;
  end

  // Next-state: run, drain leftovers, clear map slices, report
  always_comb begin
    nextState = state;
    unique case (state)
      RUN:   if (eventEnd)  nextState = DRAIN;
      DRAIN: if (fifoEmpty) nextState = CLEAR;
      CLEAR: if (lastSlice) nextState = DONE;
      DONE:  nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // Mask of map bits zeroed by the current clear slice
  always_comb begin
    clrMask = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (clearPtr == SLW'(s))
        clrMask[s*CLEARWIDTH +: CLEARWIDTH] = '1;
    end
  end

  // Hit storage; entries need no reset, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      fifoSSID[wrPtr] <= hitSSID;
      fifoInfo[wrPtr] <= hitInfo;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push)
        wrPtr <= (wrPtr == PTRW'(FIFODEPTH - 1)) ? '0 : wrPtr + 1'b1;
      if (issue)
        rdPtr <= (rdPtr == PTRW'(FIFODEPTH - 1)) ? '0 : rdPtr + 1'b1;
      if (push && !issue)      count <= count + 1'b1;
      else if (!push && issue) count <= count - 1'b1;
    end
  end

  // Seen-map update, slice clear and clear pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      map      <= '0;
      clearPtr <= '0;
    end else if (state == CLEAR) begin
      map      <= map & ~clrMask;
      clearPtr <= lastSlice ? '0 : clearPtr + 1'b1;
    end else if (issue) begin
      map[headSSID] <= 1'b1;
    end
  end

  // Registered write request and per-event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      writeRow      <= 1'b0;
      rowToWrite    <= '0;
      SSIDIsNew     <= 1'b0;
      hitInfoOut    <= '0;
      nNewSSIDs     <= '0;
      eventNewCount <= '0;
    end else begin
      writeRow <= issue;
      if (issue) begin
        rowToWrite <= headSSID;
        hitInfoOut <= headInfo;
        SSIDIsNew  <= headNew;
        if (headNew && nNewSSIDs != MAXCNT)
          nNewSSIDs <= nNewSSIDs + 1'b1;
      end
      if (state == DONE) begin
        eventNewCount <= nNewSSIDs;
        nNewSSIDs     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hit_new_map.sv
// Bench for hit_new_map: directed scenarios plus randomized traffic
// scored against a transaction-level seen-set model.
module tb_hit_new_map;

  logic        clk = 1'b0;
  logic        reset, hitValid, eventEnd, hcmReady;
  logic [7:0]  hitSSID;
  logic [15:0] hitInfo;
  logic        hitReady, writeRow, SSIDIsNew, clearDone, busy;
  logic [7:0]  rowToWrite;
  logic [15:0] hitInfoOut;
  logic [8:0]  nNewSSIDs, eventNewCount;

  hit_new_map dut (
    .clk(clk), .reset(reset),
    .hitValid(hitValid), .hitSSID(hitSSID), .hitInfo(hitInfo),
    .hitReady(hitReady), .eventEnd(eventEnd), .hcmReady(hcmReady),
    .writeRow(writeRow), .rowToWrite(rowToWrite), .SSIDIsNew(SSIDIsNew),
    .hitInfoOut(hitInfoOut), .nNewSSIDs(nNewSSIDs),
    .eventNewCount(eventNewCount), .clearDone(clearDone), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  row;
    logic [15:0] info;
    logic        isNew;
  } wr_t;

  int  nChecks = 0;
  int  nFails  = 0;
  wr_t expQ[$];
  wr_t gotQ[$];
  bit  seen[256];
  int  newCount;

  always @(posedge clk) begin
    #1;
    if (writeRow === 1'b1)
      gotQ.push_back('{rowToWrite, hitInfoOut, SSIDIsNew});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic modelAccept(input logic [7:0] s);
    logic n;
    n = !seen[s];
    seen[s] = 1'b1;
    if (n && newCount < 256) newCount++;
    return n;
  endfunction

  function automatic void modelNewEvent();
    foreach (seen[i]) seen[i] = 1'b0;
    newCount = 0;
  endfunction

  task automatic idleInputs();
    hitValid = 1'b0;
    eventEnd = 1'b0;
    hitSSID  = '0;
    hitInfo  = '0;
  endtask

  task automatic test_reset();
    logic [46:0] got;
    idleInputs();
    hcmReady = 1'b0;
    reset = 1'b1;
    step();
    step();
    got = {writeRow, rowToWrite, SSIDIsNew, hitInfoOut, nNewSSIDs,
           eventNewCount, clearDone, busy};
    nChecks++;
    if (got !== 47'd0) begin
      nFails++;
      $display("FAIL reset_outputs got=%h want=0", got);
    end
    reset = 1'b0;
    step();
    nChecks++;
    if (hitReady !== 1'b1) begin
      nFails++;
      $display("FAIL reset_hitReady got=%b want=1", hitReady);
    end
    modelNewEvent();
  endtask

  task automatic test_basic();
    logic [7:0]  ss [3];
    logic [15:0] inf [3];
    logic        nw [3];
    ss = '{8'd5, 8'd9, 8'd5};
    hcmReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        hitValid = 1'b1;
        hitSSID  = ss[c];
        inf[c]   = 16'($urandom);
        hitInfo  = inf[c];
        nChecks++;
        if (hitReady !== 1'b1) begin
          nFails++;
          $display("FAIL basic_ready c=%0d got=%b want=1", c, hitReady);
        end
        nw[c] = modelAccept(ss[c]);
      end else begin
        idleInputs();
      end
      step();
      nChecks++;
      if (writeRow !== (c >= 1 && c <= 3)) begin
        nFails++;
        $display("FAIL basic_writeRow c=%0d got=%b", c, writeRow);
      end
      if (c >= 1 && c <= 3) begin
        nChecks++;
        if ({rowToWrite, hitInfoOut, SSIDIsNew} !==
            {ss[c-1], inf[c-1], nw[c-1]}) begin
          nFails++;
          $display("FAIL basic_issue c=%0d got=%0d/%h/%b want=%0d/%h/%b",
                   c, rowToWrite, hitInfoOut, SSIDIsNew,
                   ss[c-1], inf[c-1], nw[c-1]);
        end
      end
    end
    nChecks++;
    if (nNewSSIDs !== 9'd2) begin
      nFails++;
      $display("FAIL basic_nNew got=%0d want=2", nNewSSIDs);
    end
  endtask

  task automatic test_event_end();
    int pulses = 0;
    int firstAt = -1;
    int expCnt;
    logic expNew;
    eventEnd = 1'b1;
    expCnt = newCount;
    modelNewEvent();
    step();
    eventEnd = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (clearDone === 1'b1) begin
        pulses++;
        if (firstAt < 0) firstAt = i;
      end
    end
    nChecks++;
    if (pulses != 1 || firstAt != 9) begin
      nFails++;
      $display("FAIL end_clearDone pulses=%0d at=%0d want 1 at 9",
               pulses, firstAt);
    end
    nChecks++;
    if (eventNewCount !== 9'(expCnt) || nNewSSIDs !== 9'd0) begin
      nFails++;
      $display("FAIL end_counts got=%0d/%0d want=%0d/0",
               eventNewCount, nNewSSIDs, expCnt);
    end
    nChecks++;
    if (busy !== 1'b0 || hitReady !== 1'b1) begin
      nFails++;
      $display("FAIL end_idle busy=%b ready=%b want 0/1", busy, hitReady);
    end
    hitValid = 1'b1;
    hitSSID  = 8'd5;
    hitInfo  = 16'h0505;
    expNew   = modelAccept(8'd5);
    step();
    idleInputs();
    step();
    nChecks++;
    if (writeRow !== 1'b1 || rowToWrite !== 8'd5 || SSIDIsNew !== expNew) begin
      nFails++;
      $display("FAIL end_resend got=%b/%0d/%b want=1/5/%b",
               writeRow, rowToWrite, SSIDIsNew, expNew);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] inf [4];
    logic        nw [4];
    hcmReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hitValid = 1'b1;
      hitSSID  = 8'(20 + i);
      hitInfo  = 16'($urandom);
      nChecks++;
      if (hitReady !== (i < 4)) begin
        nFails++;
        $display("FAIL bp_ready i=%0d got=%b want=%b", i, hitReady, i < 4);
      end
      if (i < 4) begin
        inf[i] = hitInfo;
        nw[i]  = modelAccept(hitSSID);
      end
      step();
    end
    idleInputs();
    step();
    nChecks++;
    if (writeRow !== 1'b0 || busy !== 1'b1) begin
      nFails++;
      $display("FAIL bp_stall writeRow=%b busy=%b want 0/1", writeRow, busy);
    end
    hcmReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      nChecks++;
      if ({writeRow, rowToWrite, hitInfoOut, SSIDIsNew} !==
          {1'b1, 8'(20 + j), inf[j], nw[j]}) begin
        nFails++;
        $display("FAIL bp_issue j=%0d got=%b/%0d/%h/%b want=1/%0d/%h/%b",
                 j, writeRow, rowToWrite, hitInfoOut, SSIDIsNew,
                 20 + j, inf[j], nw[j]);
      end
    end
    step();
    nChecks++;
    if (writeRow !== 1'b0 || hitReady !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL bp_after wr=%b ready=%b busy=%b want 0/1/0",
               writeRow, hitReady, busy);
    end
  endtask

  task automatic test_same_edge();
    int wrAt = -1;
    int doneAt = -1;
    int expCnt;
    logic [7:0] wrRow;
    logic wrNew;
    hcmReady = 1'b1;
    hitValid = 1'b1;
    hitSSID  = 8'd255;
    hitInfo  = 16'hbeef;
    eventEnd = 1'b1;
    nChecks++;
    if (hitReady !== 1'b1) begin
      nFails++;
      $display("FAIL same_ready got=%b want=1", hitReady);
    end
    void'(modelAccept(8'd255));
    expCnt = newCount;
    modelNewEvent();
    step();
    idleInputs();
    for (int i = 1; i <= 30; i++) begin
      step();
      if (writeRow === 1'b1 && wrAt < 0) begin
        wrAt  = i;
        wrRow = rowToWrite;
        wrNew = SSIDIsNew;
      end
      if (clearDone === 1'b1 && doneAt < 0) doneAt = i;
    end
    nChecks++;
    if (wrAt != 1 || wrRow !== 8'd255 || wrNew !== 1'b1) begin
      nFails++;
      $display("FAIL same_issue at=%0d row=%0d new=%b want 1/255/1",
               wrAt, wrRow, wrNew);
    end
    nChecks++;
    if (doneAt != 10) begin
      nFails++;
      $display("FAIL same_clearDone at=%0d want=10", doneAt);
    end
    nChecks++;
    if (eventNewCount !== 9'(expCnt)) begin
      nFails++;
      $display("FAIL same_count got=%0d want=%0d", eventNewCount, expCnt);
    end
  endtask

  task automatic test_random();
    int expCnt;
    int waitN;
    logic n;
    idleInputs();
    hcmReady = 1'b1;
    step();
    gotQ.delete();
    expQ.delete();
    for (int c = 0; c < 600; c++) begin
      hcmReady = ($urandom % 4) != 0;
      hitValid = $urandom % 2;
      hitSSID  = 8'($urandom % 16);
      hitInfo  = 16'($urandom);
      eventEnd = (c % 150) == 149;
      if (hitValid && hitReady) begin
        n = modelAccept(hitSSID);
        expQ.push_back('{hitSSID, hitInfo, n});
      end
      if (eventEnd) begin
        expCnt = newCount;
        modelNewEvent();
        step();
        idleInputs();
        waitN = 0;
        while (clearDone !== 1'b1 && waitN < 200) begin
          hcmReady = $urandom % 2;
          step();
          waitN++;
        end
        step();
        nChecks++;
        if (waitN >= 200 || eventNewCount !== 9'(expCnt)) begin
          nFails++;
          $display("FAIL rand_event c=%0d wait=%0d got=%0d want=%0d",
                   c, waitN, eventNewCount, expCnt);
        end
      end else begin
        step();
      end
    end
    idleInputs();
    hcmReady = 1'b1;
    waitN = 0;
    while (busy !== 1'b0 && waitN < 50) begin
      step();
      waitN++;
    end
    step();
    step();
    nChecks++;
    if (waitN >= 50 || gotQ.size() != expQ.size()) begin
      nFails++;
      $display("FAIL rand_count wait=%0d got=%0d want=%0d",
               waitN, gotQ.size(), expQ.size());
    end
    for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
      nChecks++;
      if (gotQ[i] !== expQ[i]) begin
        nFails++;
        $display("FAIL rand_write i=%0d got=%0d/%h/%b want=%0d/%h/%b", i,
                 gotQ[i].row, gotQ[i].info, gotQ[i].isNew,
                 expQ[i].row, expQ[i].info, expQ[i].isNew);
      end
    end
  endtask

  task automatic test_reset_clear();
    logic [46:0] got;
    int pulses = 0;
    hcmReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hitValid = 1'b1;
      hitSSID  = 8'(7 + i);
      hitInfo  = 16'(i);
      step();
    end
    idleInputs();
    step();
    step();
    eventEnd = 1'b1;
    step();
    eventEnd = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    modelNewEvent();
    got = {writeRow, rowToWrite, SSIDIsNew, hitInfoOut, nNewSSIDs,
           eventNewCount, clearDone, busy};
    nChecks++;
    if (got !== 47'd0 || hitReady !== 1'b1) begin
      nFails++;
      $display("FAIL rstclr_outputs got=%h ready=%b want=0/1", got, hitReady);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      if (clearDone === 1'b1) pulses++;
    end
    nChecks++;
    if (pulses != 0 || busy !== 1'b0) begin
      nFails++;
      $display("FAIL rstclr_noDone pulses=%0d busy=%b want 0/0", pulses, busy);
    end
    hitValid = 1'b1;
    hitSSID  = 8'd7;
    hitInfo  = 16'h0707;
    step();
    idleInputs();
    step();
    nChecks++;
    if (writeRow !== 1'b1 || rowToWrite !== 8'd7 || SSIDIsNew !== 1'b1) begin
      nFails++;
      $display("FAIL rstclr_mapZero got=%b/%0d/%b want=1/7/1",
               writeRow, rowToWrite, SSIDIsNew);
    end
  endtask

  initial begin
    reset    = 1'b1;
    hcmReady = 1'b0;
    idleInputs();
    test_reset();
    test_basic();
    test_event_end();
    test_backpressure();
    test_same_edge();
    test_random();
    test_reset_clear();
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
